// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the 4-bit synchronous FIFO and its read-side packer.
// Entry width and depth are common to both sides of the FIFO.
package sync_fifo_pkg;

    localparam int FIFO_DATA_W = 4;
    localparam int FIFO_DEPTH  = 16;

    // Counter width able to hold 0..pack inclusive.
    function automatic int cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_out_reg.sv
// Single-entry valid/ready output register.
// A load replaces the entry even while it is being drained in the same cycle.
module sync_fifo_out_reg #(
    parameter int W = 8
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         slot_free
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state for the held word and its valid flag.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign slot_free = !valid_q || out_ready;

endmodule

// File: rtl/sync_fifo_reader_chk.sv
// Protocol checker for sync_fifo_reader: pop legality, counter bound and
// output stability under backpressure.
module sync_fifo_reader_chk #(
    parameter int PACK  = 2,
    parameter int CNT_W = 2,
    parameter int OUT_W = 8
)(
    input logic             clk,
    input logic             rst_n,
    input logic             fifo_rd_en,
    input logic             fifo_empty,
    input logic             pending,
    input logic [CNT_W-1:0] cnt,
    input logic             out_valid,
    input logic             out_ready,
    input logic [OUT_W-1:0] out_data
);

    a_rd_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_rd_en |-> !fifo_empty);

    a_pending_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        pending |-> (cnt < CNT_W'(PACK)));

    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: rtl/sync_fifo_reader.sv
// Read side of the 4-bit synchronous FIFO: pops nibbles, packs PACK of them
// low-nibble-first into a word and offers it on a valid/ready stream.
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int  DATA_W = FIFO_DATA_W,
    parameter int  PACK   = 2,
    localparam int OUT_W  = DATA_W * PACK
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy
);

    localparam int CNT_W = cnt_width(PACK);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_sum_s;
    logic             word_done_s;
    logic             load_s;
    logic             slot_free_s;
    logic             pop_a_s;
    logic             pop_b_s;

    // Capture, word completion and pop issue.
    always_comb begin
        acc_d       = acc_q;
        cnt_sum_s   = cnt_q + CNT_W'(pending_q);
        word_done_s = 1'b0;
        load_s      = 1'b0;
        pop_a_s     = 1'b0;
        pop_b_s     = 1'b0;
        cnt_d       = cnt_q;
        pending_d   = 1'b0;
        fifo_rd_en  = 1'b0;

        if (pending_q) begin
            acc_d[int'(cnt_q) * DATA_W +: DATA_W] = fifo_data;
        end else begin
            acc_d = acc_q;
        end

        // A full word either leaves now or parks in acc with cnt == PACK.
        word_done_s = (cnt_sum_s == CNT_W'(PACK));
        load_s      = word_done_s && slot_free_s;
        cnt_d       = load_s ? '0 : cnt_sum_s;

        // Pop into slot 0 early when the completing word is leaving this cycle.
        pop_a_s    = (cnt_sum_s < CNT_W'(PACK));
        pop_b_s    = word_done_s && pending_q && slot_free_s;
        fifo_rd_en = rst_n && !fifo_empty && (pop_a_s || pop_b_s);
        pending_d  = fifo_rd_en;
    end

    // Packer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            acc_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            acc_q     <= acc_d;
        end
    end

    sync_fifo_out_reg #(
        .W (OUT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (acc_d),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .slot_free (slot_free_s)
    );

    assign busy = (cnt_q != '0) || pending_q || out_valid;

endmodule
